// File: rtl/uart_fifo_peripheral.sv
// rtl/uart_fifo_peripheral.sv - memory-mapped UART with TX/RX FIFOs, baud divisor, parity and irq
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop & (count_q != '0);
        do_push = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

    assign head  = mem_q[rptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
endmodule

module uart_fifo_peripheral #(
    parameter logic [31:0] BASE_ADDR   = 32'h40000018,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DIV_WIDTH   = 16,
    parameter int          DEFAULT_DIV = 325
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

    logic sel_tx, sel_rx, sel_con, sel_div;
    logic [3:0] con_q, con_d;
    logic [2:0] sticky_q, sticky_d;
    logic [DIV_WIDTH-1:0] div_q, div_d, bcnt_q, bcnt_d, div_eff;
    logic tick, irq_q, irq_d;

    logic       tx_push, tx_pop, tx_full, tx_empty, tx_busy;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       set_overrun, set_par, set_frame;

    uart_state_t tx_state_q, tx_state_d;
    logic [3:0]  tx_tcnt_q, tx_tcnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_bit_end;

    uart_state_t rx_state_q, rx_state_d;
    logic [3:0]  rx_tcnt_q, rx_tcnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic        rx_par_bad_q, rx_par_bad_d, rx_sample;

    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:16], wdata[12:8], wdata[7:4]};

    always_comb begin
        sel_tx  = (addr == BASE_ADDR);
        sel_rx  = (addr == BASE_ADDR + 32'd4);
        sel_con = (addr == BASE_ADDR + 32'd8);
        sel_div = (addr == BASE_ADDR + 32'd12);
    end

    assign tx_push = wr & sel_tx;
    assign rx_pop  = rd & sel_rx & ~rx_empty;
    assign tx_busy = (tx_state_q != ST_IDLE);

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .push_data(wdata[7:0]),
        .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift_q),
        .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // A divisor of zero behaves as one so the tick never stalls.
    always_comb begin
        div_eff = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
        tick    = (bcnt_q == div_eff - DIV_WIDTH'(1));
        bcnt_d  = tick ? '0 : bcnt_q + DIV_WIDTH'(1);
        div_d   = div_q;
        if (wr && sel_div) begin
            div_d  = wdata[DIV_WIDTH-1:0];
            bcnt_d = '0;
        end
        con_d = con_q;
        if (wr && sel_con) con_d = wdata[3:0];
        // Set wins over a simultaneous write-1-to-clear.
        sticky_d = (sticky_q & ~((wr && sel_con) ? wdata[15:13] : 3'b000))
                 | {set_frame, set_par, set_overrun};
        irq_d = (con_q[0] & tx_empty & ~tx_busy)
              | (con_q[1] & (~rx_empty | (|sticky_q)));
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rx && !rx_empty) rdata = {24'b0, rx_head};
            if (sel_con) rdata = {16'b0, sticky_q, tx_busy, rx_empty, rx_full,
                                  tx_empty, tx_full, 4'b0, con_q};
            if (sel_div) rdata = 32'(div_q);
        end
    end

    // Transmitter: a frame in STOP chains straight into the next START when data waits.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tcnt_d   = tick ? tx_tcnt_q + 4'd1 : tx_tcnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_par_en_d = tx_par_en_q;
        tx_pop      = 1'b0;
        txd         = 1'b1;
        tx_bit_end  = tick && (tx_tcnt_q == 4'd15);
        case (tx_state_q)
            ST_IDLE: begin
                tx_tcnt_d = '0;
                if (!tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_shift_d  = tx_head;
                    tx_par_d    = (^tx_head) ^ con_q[3];
                    tx_par_en_d = con_q[2];
                    tx_state_d  = ST_START;
                end
            end
            ST_START: begin
                txd = 1'b0;
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                txd = tx_shift_q[0];
                if (tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = tx_par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                txd = tx_par_q;
                if (tx_bit_end) tx_state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop      = 1'b1;
                        tx_shift_d  = tx_head;
                        tx_par_d    = (^tx_head) ^ con_q[3];
                        tx_par_en_d = con_q[2];
                        tx_state_d  = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Receiver: start bit confirmed half a bit in, then every sample lands mid-bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_tcnt_d    = tick ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push      = 1'b0;
        set_overrun  = 1'b0;
        set_par      = 1'b0;
        set_frame    = 1'b0;
        rx_sample    = tick && (rx_tcnt_q == 4'd15);
        case (rx_state_q)
            ST_IDLE: begin
                rx_tcnt_d = '0;
                if (tick && !rx_s2_q) begin
                    rx_par_en_d  = con_q[2];
                    rx_par_odd_d = con_q[3];
                    rx_par_bad_d = 1'b0;
                    rx_state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick && rx_tcnt_q == 4'd7) begin
                    rx_tcnt_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = rx_par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (rx_sample) begin
                    rx_par_bad_d = rx_s2_q ^ (^rx_shift_q) ^ rx_par_odd_q;
                    rx_state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_sample) begin
                    rx_state_d = ST_IDLE;
                    if (!rx_s2_q)         set_frame   = 1'b1;
                    else if (rx_par_bad_q) set_par    = 1'b1;
                    else if (rx_full)      set_overrun = 1'b1;
                    else                   rx_push    = 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            con_q        <= '0;
            sticky_q     <= '0;
            div_q        <= DIV_WIDTH'(DEFAULT_DIV);
            bcnt_q       <= '0;
            irq_q        <= 1'b0;
            tx_state_q   <= ST_IDLE;
            tx_tcnt_q    <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_par_en_q  <= 1'b0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_tcnt_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bad_q <= 1'b0;
        end else begin
            con_q        <= con_d;
            sticky_q     <= sticky_d;
            div_q        <= div_d;
            bcnt_q       <= bcnt_d;
            irq_q        <= irq_d;
            tx_state_q   <= tx_state_d;
            tx_tcnt_q    <= tx_tcnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_par_en_q  <= tx_par_en_d;
            rx_s1_q      <= rxd;
            rx_s2_q      <= rx_s1_q;
            rx_state_q   <= rx_state_d;
            rx_tcnt_q    <= rx_tcnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_par_bad_q <= rx_par_bad_d;
        end
    end

    assign irq = irq_q;
endmodule

// File: tb/tb_uart_fifo_peripheral.sv
// tb/tb_uart_fifo_peripheral.sv - scoreboard bench for uart_fifo_peripheral
module tb_uart_fifo_peripheral;
    localparam logic [31:0] A_TX  = 32'h40000018;
    localparam logic [31:0] A_RX  = 32'h4000001C;
    localparam logic [31:0] A_CON = 32'h40000020;
    localparam logic [31:0] A_DIV = 32'h40000024;

    logic        reset, clk, rd, wr, rxd, txd, irq;
    logic [31:0] addr, wdata, rdata;
    logic        loop_en, rxd_drv;
    logic        trace [1000];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          failures = 0;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_fifo_peripheral dut (
        .reset(reset), .clk(clk), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic rx_check(input string tag);
        logic [31:0] d, e;
        bus_read(A_RX, d);
        e = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) e = {24'b0, exp_q.pop_front()};
        check(tag, d, e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_en, input bit par_odd,
                              input bit stop_bit);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (16) @(negedge clk);
        end
        if (par_en) begin
            rxd_drv = (^b) ^ par_odd;
            repeat (16) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (16) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    task automatic watch_tx(output int n);
        int w;
        w = 0;
        n = 0;
        rd = 1'b1; addr = A_CON;
        #1;
        while (rdata[12] !== 1'b1 && w < 50) begin
            @(negedge clk); #1; w++;
        end
        while (rdata[12] === 1'b1 && n < 1000) begin
            trace[n] = txd; n++;
            @(negedge clk); #1;
        end
        rd = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  pat;
        logic        ebit;
        int          n;

        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        loop_en = 1'b0; rxd_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b1;

        bus_read(A_CON, d);          check("rst_con", d, 32'h0A00);
        bus_read(A_DIV, d);          check("rst_div", d, 32'd325);
        bus_read(A_TX, d);           check("txdata_read", d, 32'd0);
        bus_read(A_DIV + 32'd4, d);  check("unmapped_read", d, 32'd0);
        bus_read(A_RX, d);           check("rx_empty_read", d, 32'd0);
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, d);          check("div_write", d, 32'd1);

        // Single 8N1 frame, bit-level waveform
        pat = 8'h5A;
        bus_write(A_TX, 32'h5A);
        watch_tx(n);
        check("tx_busy_len", 32'(n), 32'd160);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) ebit = 1'b0;
            else if (i == 9) ebit = 1'b1;
            else ebit = pat[i-1];
            check($sformatf("tx_bit%0d", i), 32'(trace[16*i+8]), 32'(ebit));
        end
        bus_read(A_CON, d);          check("tx_done_con", d, 32'h0A00);
        check("irq_off", 32'(irq), 32'd0);

        // Loopback, odd parity, back-to-back frames
        bus_write(A_CON, 32'h0C);
        loop_en = 1'b1;
        @(negedge clk);
        wr = 1'b1; addr = A_TX; wdata = 32'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        wdata = 32'h3C; exp_q.push_back(8'h3C);
        @(negedge clk);
        wr = 1'b0;
        watch_tx(n);
        check("loop_busy_len", 32'(n), 32'd352);
        check("loop_par1", 32'(trace[152]), 32'd1);
        check("loop_start2", 32'(trace[184]), 32'd0);
        check("loop_par2", 32'(trace[328]), 32'd1);
        repeat (4) @(negedge clk);
        loop_en = 1'b0;
        rx_check("loop_rx0");
        rx_check("loop_rx1");
        bus_read(A_CON, d);          check("loop_con", d, 32'h0A0C);

        // Overrun: one frame more than the FIFO holds
        bus_write(A_CON, 32'h0);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 8) exp_q.push_back(b);
            send_frame(b, 1'b0, 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        bus_read(A_CON, d);          check("ovr_con", d, 32'h2600);
        bus_write(A_CON, 32'h2000);
        bus_read(A_CON, d);          check("ovr_clear", d, 32'h0600);
        for (int i = 0; i < 8; i++) rx_check($sformatf("ovr_rx%0d", i));
        bus_read(A_CON, d);          check("ovr_drained", d, 32'h0A00);

        // Framing error, then a short glitch
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        bus_read(A_CON, d);          check("frame_err", d, 32'h8A00);
        bus_write(A_CON, 32'h8000);
        bus_read(A_CON, d);          check("frame_clear", d, 32'h0A00);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(A_CON, d);          check("glitch_con", d, 32'h0A00);

        // Interrupts
        bus_write(A_CON, 32'h2);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("irq_rx_set", 32'(irq), 32'd1);
        rx_check("irq_rx_byte");
        @(negedge clk);
        check("irq_rx_clr", 32'(irq), 32'd0);
        bus_write(A_CON, 32'h1);
        @(negedge clk);
        check("irq_tx_idle", 32'(irq), 32'd1);

        // Reset mid-frame
        bus_write(A_CON, 32'h0);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h11);
        repeat (30) @(negedge clk);
        check("pre_rst_txd", 32'(txd), 32'd0);
        reset = 1'b0;
        #1 check("mid_rst_txd", 32'(txd), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(A_CON, d);          check("post_rst_con", d, 32'h0A00);
        bus_read(A_DIV, d);          check("post_rst_div", d, 32'd325);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
